// File: rtl/hex_disp_pkg.sv
// Shared constants for the hex scan display: segment width, the hex-to-segment
// code table and a helper that sizes counters.
package hex_disp_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = '0;

  // Segment order {a,b,c,d,e,f,g}, indexed by nibble value 0..F.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Bits needed to hold 0..n-1; never less than one.
  function automatic int cnt_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to 7-segment decoder.
module hex_seg_decode
  import hex_disp_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/hex_scan_display.sv
// Multiplexed hex display driver with a frame-synchronous load handshake.
// Optional leading-zero suppression is enabled by defining HEX_SCAN_LZ_BLANK_EN.
module hex_scan_display
  import hex_disp_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 1000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] load_data,
  input  logic                    load_valid,
  output logic                    load_ready,
  input  logic                    blank,
  output logic [SEG_W-1:0]        seg,
  output logic [NUM_DIGITS-1:0]   dig_sel,
  output logic                    frame_done
);

  localparam int DATA_W = 4 * NUM_DIGITS;
  localparam int PW     = cnt_width(SCAN_DIV);
  localparam int IW     = cnt_width(NUM_DIGITS);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  logic [PW-1:0]     presc_reg;
  logic [IW-1:0]     idx_reg;
  logic [DATA_W-1:0] disp_reg;
  logic [DATA_W-1:0] pend_reg;
  logic              pend_full_reg;

  logic              tc;
  logic              frame_end;
  logic              accept;
  logic [3:0]        nibble;
  logic              lz_cur;
  logic [SEG_W-1:0]  dec_seg;
  logic [SEG_W-1:0]  seg_next;
  logic [NUM_DIGITS-1:0] lz;

  assign tc         = (presc_reg == PRESC_LAST);
  assign frame_end  = tc && (idx_reg == IDX_LAST);
  assign load_ready = ~pend_full_reg;
  assign accept     = load_valid && ~pend_full_reg;

`ifdef HEX_SCAN_LZ_BLANK_EN
  // Digit k is a leading zero when it and every higher nibble are zero;
  // digit 0 is never suppressed so an all-zero word still shows "0".
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_low
        assign lz[gi] = 1'b0;
      end else begin : g_high
        assign lz[gi] = ~|disp_reg[DATA_W-1:4*gi];
      end
    end
  endgenerate
`else
  assign lz = '0;
`endif

  always_comb begin
    nibble = '0;
    lz_cur = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_reg == IW'(k)) begin
        nibble = disp_reg[4*k +: 4];
        lz_cur = lz[k];
      end
    end
  end

  hex_seg_decode u_dec (
    .nibble (nibble),
    .seg    (dec_seg)
  );

  assign seg_next = lz_cur ? SEG_BLANK : dec_seg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_reg <= '0;
      idx_reg   <= '0;
    end else if (tc) begin
      presc_reg <= '0;
      idx_reg   <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  // Accept and commit are mutually exclusive: accept needs the pending slot
  // empty, commit needs it full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_reg      <= '0;
      pend_full_reg <= 1'b0;
      disp_reg      <= '0;
    end else if (accept) begin
      pend_reg      <= load_data;
      pend_full_reg <= 1'b1;
    end else if (frame_end && pend_full_reg) begin
      disp_reg      <= pend_reg;
      pend_full_reg <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= SEG_BLANK;
      dig_sel    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= frame_end;
      if (blank) begin
        seg     <= SEG_BLANK;
        dig_sel <= '0;
      end else begin
        seg     <= seg_next;
        dig_sel <= NUM_DIGITS'(1) << idx_reg;
      end
    end
  end

endmodule
